// File: rtl/pcap_ts_marker_merge_if.sv
// AXI4-Stream bundle for the pcap timestamp merge stage.
// Signals: tdata, tkeep, tuser, tvalid, tready, tlast; master drives data, slave drives tready.
interface pcap_ts_marker_merge_if #(
    parameter int DW = 256,
    parameter int UW = 128
) ();
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic [UW-1:0]   tuser;
    logic            tvalid;
    logic            tready;
    logic            tlast;

    modport master (
        output tdata, tkeep, tuser, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tuser, tvalid, tlast,
        output tready
    );
endinterface

// File: rtl/pcap_ts_marker_merge.sv
// Detects timestamp marker packets, extracts a big-endian ts and writes it into the
// tuser of every beat of the next data packet; marker/orphan counters; one output slice.
// Ports: axis_aclk, axis_areset (async, active-high), mode[1:0] (0 bypass, 1 merge+drop,
//   2 merge+keep, 3 = 0), s_axis (slave stream in), m_axis (master stream out),
//   marker_cnt / orphan_cnt (32-bit wrapping counters).
module pcap_ts_marker_merge #(
    parameter int          C_AXIS_DATA_WIDTH  = 256,
    parameter int          C_AXIS_TUSER_WIDTH = 128,
    parameter logic [63:0] SIG_VALUE          = 64'h00000000_efbeadde,
    parameter int          TS_BYTE_OFFSET     = 12,
    parameter int          TS_BYTES           = 4,
    parameter int          TS_TUSER_OFFSET    = 32
) (
    input  logic                          axis_aclk,
    input  logic                          axis_areset,
    input  logic [1:0]                    mode,
    pcap_ts_marker_merge_if.slave         s_axis,
    pcap_ts_marker_merge_if.master        m_axis,
    output logic [31:0]                   marker_cnt,
    output logic [31:0]                   orphan_cnt
);
    localparam int DW = C_AXIS_DATA_WIDTH;
    localparam int KW = C_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_AXIS_TUSER_WIDTH;
    localparam int TW = TS_BYTES * 8;

    typedef enum logic [1:0] {ST_HEAD, ST_MARK, ST_BODY} state_t;

    state_t         r_state, w_state_nxt;
    logic [1:0]     r_mode, w_mode;
    logic           r_ts_valid, r_tag;
    logic [TW-1:0]  r_ts_pend, w_ts;
    logic [31:0]    r_marker_cnt, r_orphan_cnt;
    logic           r_m_valid, r_m_last;
    logic [DW-1:0]  r_m_data;
    logic [KW-1:0]  r_m_keep;
    logic [UW-1:0]  r_m_user, w_user;
    logic           w_marker, w_drop, w_tag;
    logic           w_ready, w_fire, w_fwd;

    // Reserved mode 3 behaves as bypass.
    assign w_mode   = (mode == 2'd3) ? 2'd0 : mode;
    assign w_marker = (s_axis.tdata[63:0] == SIG_VALUE) && (w_mode != 2'd0);

    // Byte TS_BYTE_OFFSET on the bus becomes the ts MSB.
    always_comb begin
        w_ts = '0;
        for (int i = 0; i < TS_BYTES; i++) begin
            w_ts[(TS_BYTES-1-i)*8 +: 8] = s_axis.tdata[(TS_BYTE_OFFSET+i)*8 +: 8];
        end
    end

    // Next state assumes the current beat fires; the register only
    // advances on a handshake, which keeps tready out of this block.
    always_comb begin
        w_state_nxt = r_state;
        w_drop      = 1'b0;
        w_tag       = 1'b0;
        unique case (r_state)
            ST_HEAD: begin
                if (w_marker) begin
                    w_drop      = (w_mode == 2'd1);
                    w_state_nxt = s_axis.tlast ? ST_HEAD : ST_MARK;
                end else begin
                    w_tag       = r_ts_valid && (w_mode != 2'd0);
                    w_state_nxt = s_axis.tlast ? ST_HEAD : ST_BODY;
                end
            end
            ST_MARK: begin
                w_drop      = (r_mode == 2'd1);
                w_state_nxt = s_axis.tlast ? ST_HEAD : ST_MARK;
            end
            ST_BODY: begin
                w_tag       = r_tag;
                w_state_nxt = s_axis.tlast ? ST_HEAD : ST_BODY;
            end
            default: w_state_nxt = ST_HEAD;
        endcase
    end

    // Dropped beats never touch the output slice, so they are always accepted.
    assign w_ready       = w_drop | ~r_m_valid | m_axis.tready;
    assign w_fire        = s_axis.tvalid & w_ready;
    assign w_fwd         = w_fire & ~w_drop;
    assign s_axis.tready = w_ready;

    always_comb begin
        w_user = s_axis.tuser;
        if (w_tag) begin
            w_user[TS_TUSER_OFFSET +: TW] = r_ts_pend;
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            r_state <= ST_HEAD;
        end else if (w_fire) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_m_keep     <= '0;
            r_m_user     <= '0;
            r_m_last     <= 1'b0;
            r_mode       <= 2'd0;
            r_ts_valid   <= 1'b0;
            r_ts_pend    <= '0;
            r_tag        <= 1'b0;
            r_marker_cnt <= '0;
            r_orphan_cnt <= '0;
        end else begin
            if (w_fwd) begin
                r_m_valid <= 1'b1;
                r_m_data  <= s_axis.tdata;
                r_m_keep  <= s_axis.tkeep;
                r_m_user  <= w_user;
                r_m_last  <= s_axis.tlast;
            end else if (m_axis.tready) begin
                r_m_valid <= 1'b0;
            end

            if (w_fire && r_state == ST_HEAD) begin
                r_mode <= w_mode;
                if (w_marker) begin
                    r_marker_cnt <= r_marker_cnt + 32'd1;
                    if (r_ts_valid) begin
                        r_orphan_cnt <= r_orphan_cnt + 32'd1;
                    end
                    r_ts_pend  <= w_ts;
                    r_ts_valid <= 1'b1;
                end else if (w_tag) begin
                    r_ts_valid <= 1'b0;
                    r_tag      <= ~s_axis.tlast;
                end
            end

            if (w_fire && r_state == ST_BODY && s_axis.tlast) begin
                r_tag <= 1'b0;
            end
        end
    end

    assign m_axis.tvalid = r_m_valid;
    assign m_axis.tdata  = r_m_data;
    assign m_axis.tkeep  = r_m_keep;
    assign m_axis.tuser  = r_m_user;
    assign m_axis.tlast  = r_m_last;
    assign marker_cnt    = r_marker_cnt;
    assign orphan_cnt    = r_orphan_cnt;
endmodule

// File: tb/tb_pcap_ts_marker_merge.sv
// Directed bench for pcap_ts_marker_merge: marker merge in each mode, chained
// markers, random output backpressure with hold checks, and mid-packet reset.
module tb_pcap_ts_marker_merge;
    localparam int DW = 256;
    localparam int KW = 32;
    localparam int UW = 128;
    localparam logic [63:0] SIG = 64'h00000000_efbeadde;
    localparam logic [KW-1:0] KF = '1;
    localparam logic [KW-1:0] KH = 32'h0000_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [31:0] marker_cnt, orphan_cnt;
    logic        rdy_mode = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    beat_t q[$];
    beat_t exp_q[$];

    pcap_ts_marker_merge_if #(.DW(DW), .UW(UW)) s_if ();
    pcap_ts_marker_merge_if #(.DW(DW), .UW(UW)) m_if ();

    pcap_ts_marker_merge #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(UW)
    ) dut (
        .axis_aclk  (clk),
        .axis_areset(rst),
        .mode       (mode),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .marker_cnt (marker_cnt),
        .orphan_cnt (orphan_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] dbeat(input int idx);
        logic [31:0] w;
        w = 32'h1000_0000 + idx;
        return {8{w}};
    endfunction

    function automatic logic [UW-1:0] ubeat(input int idx);
        logic [31:0] w;
        w = 32'hC0DE_0000 + idx;
        return {4{w}};
    endfunction

    function automatic logic [DW-1:0] mk_marker(input logic [31:0] ts, input int idx);
        logic [DW-1:0] d;
        d = dbeat(idx);
        d[63:0]   = SIG;
        d[96+:8]  = ts[31:24];
        d[104+:8] = ts[23:16];
        d[112+:8] = ts[15:8];
        d[120+:8] = ts[7:0];
        return d;
    endfunction

    function automatic logic [UW-1:0] tagu(input logic [UW-1:0] u, input logic [31:0] ts);
        logic [UW-1:0] r;
        r = u;
        r[63:32] = ts;
        return r;
    endfunction

    // Output monitor: sets tready, checks hold while stalled, records transfers.
    logic          stall_prev = 1'b0;
    logic [DW-1:0] p_d;
    logic [UW-1:0] p_u;
    logic [KW-1:0] p_k;
    logic          p_l;

    always @(negedge clk) begin
        if (rdy_mode) m_if.tready = ($urandom_range(0, 9) >= 3);
        else          m_if.tready = 1'b1;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", m_if.tvalid, 1'b1);
                chk("hold_data", m_if.tdata, p_d);
                chk("hold_user", m_if.tuser, p_u);
                chk("hold_keep_last", {m_if.tkeep, m_if.tlast}, {p_k, p_l});
            end
            if (m_if.tvalid === 1'b1 && m_if.tready) begin
                q.push_back('{d: m_if.tdata, k: m_if.tkeep, u: m_if.tuser, l: m_if.tlast});
            end
            stall_prev = (m_if.tvalid === 1'b1) && !m_if.tready;
            p_d = m_if.tdata;
            p_u = m_if.tuser;
            p_k = m_if.tkeep;
            p_l = m_if.tlast;
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                             input logic [UW-1:0] u, input logic l);
        int n = 0;
        @(negedge clk);
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tuser  = u;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        #1;
        while (!s_if.tready && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 500) chk("send_tready_timeout", s_if.tready, 1'b1);
        @(posedge clk);
        #1 s_if.tvalid = 1'b0;
    endtask

    task automatic expect_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                               input logic [UW-1:0] u, input logic l);
        exp_q.push_back('{d: d, k: k, u: u, l: l});
    endtask

    task automatic compare_out(input string tag);
        int t = 0;
        int n = exp_q.size();
        while (q.size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_count"}, q.size(), n);
        for (int i = 0; i < n && i < q.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), q[i].d, exp_q[i].d);
            chk($sformatf("%s_user%0d", tag, i), q[i].u, exp_q[i].u);
            chk($sformatf("%s_kl%0d", tag, i), {q[i].k, q[i].l}, {exp_q[i].k, exp_q[i].l});
        end
        q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #3 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk({tag, "_m_valid"}, m_if.tvalid, 1'b0);
        chk({tag, "_m_data"}, m_if.tdata, '0);
        chk({tag, "_m_user"}, m_if.tuser, '0);
        chk({tag, "_m_kl"}, {m_if.tkeep, m_if.tlast}, '0);
        chk({tag, "_cnts"}, {marker_cnt, orphan_cnt}, '0);
        chk({tag, "_s_ready"}, s_if.tready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        exp_q.delete();
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tuser  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;

        do_reset("rst0");

        // 1: mode 1 drops the marker and tags every beat of the next packet.
        mode = 2'd1;
        send_beat(mk_marker(32'h12345678, 0), KF, ubeat(0), 1'b0);
        send_beat(dbeat(1), KH, ubeat(1), 1'b1);
        for (int b = 0; b < 3; b++) begin
            send_beat(dbeat(10 + b), (b == 2) ? KH : KF, ubeat(10 + b), b == 2);
            expect_beat(dbeat(10 + b), (b == 2) ? KH : KF,
                        tagu(ubeat(10 + b), 32'h12345678), b == 2);
        end
        compare_out("t1");
        chk("t1_marker_cnt", marker_cnt, 32'd1);
        chk("t1_orphan_cnt", orphan_cnt, 32'd0);

        // 2: mode 2 forwards the marker untouched.
        mode = 2'd2;
        send_beat(mk_marker(32'h12345678, 0), KF, ubeat(0), 1'b0);
        expect_beat(mk_marker(32'h12345678, 0), KF, ubeat(0), 1'b0);
        send_beat(dbeat(1), KH, ubeat(1), 1'b1);
        expect_beat(dbeat(1), KH, ubeat(1), 1'b1);
        for (int b = 0; b < 3; b++) begin
            send_beat(dbeat(20 + b), (b == 2) ? KH : KF, ubeat(20 + b), b == 2);
            expect_beat(dbeat(20 + b), (b == 2) ? KH : KF,
                        tagu(ubeat(20 + b), 32'h12345678), b == 2);
        end
        compare_out("t2");
        chk("t2_marker_cnt", marker_cnt, 32'd2);
        chk("t2_orphan_cnt", orphan_cnt, 32'd0);

        // 3: back-to-back markers, second ts wins.
        do_reset("rst3");
        mode = 2'd1;
        send_beat(mk_marker(32'h0000000A, 0), KH, ubeat(0), 1'b1);
        send_beat(mk_marker(32'h0000000B, 1), KH, ubeat(1), 1'b1);
        send_beat(dbeat(30), KF, ubeat(30), 1'b0);
        expect_beat(dbeat(30), KF, tagu(ubeat(30), 32'h0000000B), 1'b0);
        send_beat(dbeat(31), KH, ubeat(31), 1'b1);
        expect_beat(dbeat(31), KH, tagu(ubeat(31), 32'h0000000B), 1'b1);
        compare_out("t3");
        chk("t3_marker_cnt", marker_cnt, 32'd2);
        chk("t3_orphan_cnt", orphan_cnt, 32'd1);

        // 4: mode 0 bypass, then a mode 1 packet proves no ts was latched.
        do_reset("rst4");
        mode = 2'd0;
        send_beat(mk_marker(32'hDEADBEEF, 0), KF, ubeat(40), 1'b0);
        expect_beat(mk_marker(32'hDEADBEEF, 0), KF, ubeat(40), 1'b0);
        send_beat(dbeat(41), KH, ubeat(41), 1'b1);
        expect_beat(dbeat(41), KH, ubeat(41), 1'b1);
        for (int b = 0; b < 3; b++) begin
            send_beat(dbeat(42 + b), (b == 2) ? KH : KF, ubeat(42 + b), b == 2);
            expect_beat(dbeat(42 + b), (b == 2) ? KH : KF, ubeat(42 + b), b == 2);
        end
        compare_out("t4");
        chk("t4_cnts", {marker_cnt, orphan_cnt}, '0);
        mode = 2'd1;
        send_beat(dbeat(45), KH, ubeat(45), 1'b1);
        expect_beat(dbeat(45), KH, ubeat(45), 1'b1);
        compare_out("t4b");

        // 5: random output stalls, alternating marker / packet.
        rdy_mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [31:0] ts;
            ts = 32'hA000_0000 + i * 32'h0101;
            send_beat(mk_marker(ts, 50 + i), KH, ubeat(50 + i), 1'b1);
            send_beat(dbeat(60 + 2 * i), KF, ubeat(60 + 2 * i), 1'b0);
            expect_beat(dbeat(60 + 2 * i), KF, tagu(ubeat(60 + 2 * i), ts), 1'b0);
            send_beat(dbeat(61 + 2 * i), KH, ubeat(61 + 2 * i), 1'b1);
            expect_beat(dbeat(61 + 2 * i), KH, tagu(ubeat(61 + 2 * i), ts), 1'b1);
        end
        compare_out("t5");
        rdy_mode = 1'b0;
        chk("t5_marker_cnt", marker_cnt, 32'd10);
        chk("t5_orphan_cnt", orphan_cnt, 32'd0);

        // 6: reset inside a tagged packet; pending ts and tag are discarded.
        mode = 2'd1;
        send_beat(mk_marker(32'h00000077, 0), KH, ubeat(0), 1'b1);
        send_beat(mk_marker(32'h00000078, 1), KH, ubeat(1), 1'b1);
        send_beat(dbeat(80), KF, ubeat(80), 1'b0);
        send_beat(dbeat(81), KF, ubeat(81), 1'b0);
        do_reset("rst6");
        send_beat(dbeat(90), KF, ubeat(90), 1'b0);
        expect_beat(dbeat(90), KF, ubeat(90), 1'b0);
        send_beat(dbeat(91), KH, ubeat(91), 1'b1);
        expect_beat(dbeat(91), KH, ubeat(91), 1'b1);
        compare_out("t6");
        chk("t6_cnts", {marker_cnt, orphan_cnt}, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
